process_message_queue: RTL and testbench

//  Inter-process mailbox downstream of the core's control unit send/receive strobes.

---
 rtl/bmcore_msgq_pkg.sv | 39 +++
 rtl/msgq_fifo_ram.sv | 36 +++
 rtl/process_message_queue.sv | 172 +++++++++++++++++
 tb/tb_process_message_queue.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmcore_msgq_pkg.sv
// -----------------------------------------------------------------------------
// bmcore_msgq_pkg
// Shared types and constants for the inter-process message queue.
//   msg_t       : one queued message {src, dst, payload}
//   state_t     : receive FSM states (IDLE, WAIT, DELIVER)
//   BROADCAST_ID: all-ones process id
//   dst_matches : decides whether a head message may be consumed by a process.
// Optional feature macro: MSGQ_BROADCAST_EN -- when defined, a message whose
// dst is BROADCAST_ID matches any receiver; otherwise it matches only itself.
// -----------------------------------------------------------------------------
package bmcore_msgq_pkg;

  localparam int MSGQ_DATA_W = 32;
  localparam int MSGQ_PROC_W = 6;

  localparam logic [MSGQ_PROC_W-1:0] BROADCAST_ID = '1;

  typedef struct packed {
    logic [MSGQ_PROC_W-1:0] src;
    logic [MSGQ_PROC_W-1:0] dst;
    logic [MSGQ_DATA_W-1:0] payload;
  } msg_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DELIVER = 2'd2
  } state_t;

  function automatic logic dst_matches(input logic [MSGQ_PROC_W-1:0] dst,
                                       input logic [MSGQ_PROC_W-1:0] proc);
`ifdef MSGQ_BROADCAST_EN
    return (dst == proc) || (dst == BROADCAST_ID);
`else
    return (dst == proc);
`endif
  endfunction

endpackage

// File: rtl/msgq_fifo_ram.sv
// -----------------------------------------------------------------------------
// msgq_fifo_ram
// DEPTH x msg_t message storage: synchronous write, asynchronous read so the
// head message is visible in the same cycle the read pointer points at it.
// Contents are not reset; validity is tracked by the owner's count.
// Ports:
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write slot
//   i_wdata : message to store
//   i_raddr : read slot (head pointer)
//   o_rdata : message at i_raddr
// -----------------------------------------------------------------------------
module msgq_fifo_ram
  import bmcore_msgq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  msg_t          i_wdata,
  input  logic [AW-1:0] i_raddr,
  output msg_t          o_rdata
);

  msg_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/process_message_queue.sv
// -----------------------------------------------------------------------------
// process_message_queue
// In-order inter-process mailbox. SEND enqueues {exec_proc, dst_proc,
// send_data}; RECEIVE delivers the head message to the executing process or
// stalls it until the head belongs to it. Strictly in-order: no search past a
// head that belongs to another process.
// Handshake: recv_valid is a one-cycle pulse with recv_data/recv_src; there is
// no back-pressure, the consumer must take the data in that cycle. recv_stall
// is high from the receive cycle (combinationally) until the DELIVER cycle.
// Optional feature macro: MSGQ_BROADCAST_EN (all-ones dst matches any receiver).
// Ports:
//   single_clk, rst          : clock, async active-high reset
//   send, receive            : control strobes
//   exec_proc, dst_proc      : executing process id, destination id for send
//   send_data                : payload for send
//   recv_data, recv_src      : delivered payload / sender id (valid with recv_valid)
//   recv_valid, recv_stall   : delivery pulse, core stall
//   full, empty, count       : occupancy (registered from next count, exact)
//   overflow                 : sticky, a send was dropped while full
//   dbg_state                : current receive FSM state
// DATA_W and PROC_W must equal the package widths used by msg_t.
// -----------------------------------------------------------------------------
module process_message_queue
  import bmcore_msgq_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = MSGQ_DATA_W,
  parameter int PROC_W = MSGQ_PROC_W
) (
  input  logic                     single_clk,
  input  logic                     rst,
  input  logic                     send,
  input  logic                     receive,
  input  logic [PROC_W-1:0]        exec_proc,
  input  logic [PROC_W-1:0]        dst_proc,
  input  logic [DATA_W-1:0]        send_data,
  output logic [DATA_W-1:0]        recv_data,
  output logic [PROC_W-1:0]        recv_src,
  output logic                     recv_valid,
  output logic                     recv_stall,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output state_t                   dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;
  state_t            r_state;
  logic [PROC_W-1:0] r_req_proc;
  logic [DATA_W-1:0] r_recv_data;
  logic [PROC_W-1:0] r_recv_src;
  logic              r_recv_valid;

  msg_t              w_wr_msg;
  msg_t              w_head;
  logic              w_do_write;
  logic              w_do_read;
  logic [CW-1:0]     w_next_count;
  logic              w_head_for_exec;
  logic              w_head_for_req;

  assign w_wr_msg.src     = exec_proc;
  assign w_wr_msg.dst     = dst_proc;
  assign w_wr_msg.payload = send_data;

  // A send while full is dropped even if DELIVER frees a slot this same cycle.
  assign w_do_write = send && !r_full;
  // The head leaves the queue at the end of the DELIVER cycle.
  assign w_do_read  = (r_state == DELIVER) && !r_empty;

  assign w_head_for_exec = !r_empty && dst_matches(w_head.dst, exec_proc);
  assign w_head_for_req  = !r_empty && dst_matches(w_head.dst, r_req_proc);

  always_comb begin
    w_next_count = r_count;
    case ({w_do_write, w_do_read})
      2'b10:   w_next_count = r_count + CW'(1);
      2'b01:   w_next_count = r_count - CW'(1);
      default: w_next_count = r_count;
    endcase
  end

  msgq_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .i_clk   (single_clk),
    .i_we    (w_do_write),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_msg),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  // Pointers and flags; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge single_clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_write)      r_wr_ptr   <= r_wr_ptr + AW'(1);
      if (w_do_read)       r_rd_ptr   <= r_rd_ptr + AW'(1);
      if (send && r_full)  r_overflow <= 1'b1;
      r_count <= w_next_count;
      r_full  <= (w_next_count == CW'(DEPTH));
      r_empty <= (w_next_count == '0);
    end
  end

  // Receive FSM. recv_valid/data/src are loaded on the edge that enters
  // DELIVER so they are valid for exactly the DELIVER cycle.
  always_ff @(posedge single_clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req_proc   <= '0;
      r_recv_data  <= '0;
      r_recv_src   <= '0;
      r_recv_valid <= 1'b0;
    end else begin
      r_recv_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (receive) begin
            r_req_proc <= exec_proc;
            if (w_head_for_exec) begin
              r_state      <= DELIVER;
              r_recv_valid <= 1'b1;
              r_recv_data  <= w_head.payload;
              r_recv_src   <= w_head.src;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (w_head_for_req) begin
            r_state      <= DELIVER;
            r_recv_valid <= 1'b1;
            r_recv_data  <= w_head.payload;
            r_recv_src   <= w_head.src;
          end
        end
        DELIVER: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stall must reach the core in the same cycle as an unsatisfiable receive.
  assign recv_stall = (r_state == WAIT) ||
                      ((r_state == IDLE) && receive && !w_head_for_exec);

  assign recv_data  = r_recv_data;
  assign recv_src   = r_recv_src;
  assign recv_valid = r_recv_valid;
  assign full       = r_full;
  assign empty      = r_empty;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_process_message_queue.sv
// -----------------------------------------------------------------------------
// tb_process_message_queue
// Bench for process_message_queue: directed scenarios plus a randomized phase.
// The reference model is a plain message queue with a sticky overflow bit;
// deliveries expected from it are pushed into exp_q and a negedge monitor
// pops and compares whenever recv_valid is seen.
// -----------------------------------------------------------------------------
module tb_process_message_queue;
  import bmcore_msgq_pkg::*;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int PROC_W = 6;
  localparam int CW     = 4;
  localparam int W      = PROC_W + DATA_W;

  logic              single_clk = 1'b0;
  logic              rst        = 1'b1;
  logic              send       = 1'b0;
  logic              receive    = 1'b0;
  logic [PROC_W-1:0] exec_proc  = '0;
  logic [PROC_W-1:0] dst_proc   = '0;
  logic [DATA_W-1:0] send_data  = '0;
  logic [DATA_W-1:0] recv_data;
  logic [PROC_W-1:0] recv_src;
  logic              recv_valid;
  logic              recv_stall;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              overflow;
  state_t            dbg_state;

  process_message_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PROC_W(PROC_W)) dut (
    .single_clk (single_clk),
    .rst        (rst),
    .send       (send),
    .receive    (receive),
    .exec_proc  (exec_proc),
    .dst_proc   (dst_proc),
    .send_data  (send_data),
    .recv_data  (recv_data),
    .recv_src   (recv_src),
    .recv_valid (recv_valid),
    .recv_stall (recv_stall),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 single_clk = ~single_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model and scoreboard ----------------
  typedef struct {
    logic [PROC_W-1:0] src;
    logic [PROC_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } m_t;

  m_t             mq[$];
  logic [W-1:0]   exp_q[$];
  logic           m_ovf = 1'b0;
  int             n_cmp = 0;
  int             n_err = 0;

  function automatic bit ref_match(input logic [PROC_W-1:0] dst, input logic [PROC_W-1:0] proc);
`ifdef MSGQ_BROADCAST_EN
    return (dst == proc) || (dst == {PROC_W{1'b1}});
`else
    return (dst == proc);
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge single_clk) begin : monitor
    logic [W-1:0] e;
    if (recv_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rx_unexpected: got src=%0h data=%0h expected no delivery", recv_src, recv_data);
      end else begin
        e = exp_q.pop_front();
        chk("rx_msg", 64'({recv_src, recv_data}), 64'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge single_clk);
    #1;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_count"},    64'(count),    64'(mq.size()));
    chk({tag, "_full"},     64'(full),     64'(mq.size() == DEPTH));
    chk({tag, "_empty"},    64'(empty),    64'(mq.size() == 0));
    chk({tag, "_overflow"}, 64'(overflow), 64'(m_ovf));
  endtask

  task automatic do_reset();
    send    = 1'b0;
    receive = 1'b0;
    rst     = 1'b1;
    mq.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_stall",  64'(recv_stall), 64'(0));
    chk("rst_valid",  64'(recv_valid), 64'(0));
    chk("rst_data",   64'(recv_data),  64'(0));
    chk("rst_src",    64'(recv_src),   64'(0));
    chk("rst_state",  64'(dbg_state),  64'(IDLE));
    check_flags("rst");
  endtask

  task automatic do_send(input logic [PROC_W-1:0] src, input logic [PROC_W-1:0] dst,
                         input logic [DATA_W-1:0] data);
    m_t m;
    m.src = src; m.dst = dst; m.data = data;
    exec_proc = src;
    dst_proc  = dst;
    send_data = data;
    send      = 1'b1;
    if (mq.size() < DEPTH) mq.push_back(m);
    else m_ovf = 1'b1;
    tick();
    send = 1'b0;
  endtask

  // Receive when the model head belongs to proc: delivery one cycle later.
  task automatic do_recv_hit(input logic [PROC_W-1:0] proc);
    m_t h;
    if (mq.size() == 0) return;
    if (!ref_match(mq[0].dst, proc)) return;
    h = mq.pop_front();
    exp_q.push_back({h.src, h.data});
    exec_proc = proc;
    receive   = 1'b1;
    #1;
    chk("rx_nostall", 64'(recv_stall), 64'(0));
    tick();
    receive = 1'b0;
    chk("rx_latency", 64'(recv_valid), 64'(1));
    tick();
    chk("rx_pulse", 64'(recv_valid), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_t h;
    do_reset();

    // Basic send then matching receive.
    do_send(6'd2, 6'd5, 32'hDEAD_BEEF);
    do_recv_hit(6'd5);
    check_flags("t2");

    // Receive on empty queue waits; a later matching send is delivered.
    exec_proc = 6'd3;
    receive   = 1'b1;
    #1;
    chk("t3_stall_comb", 64'(recv_stall), 64'(1));
    tick();
    receive = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_wait_stall", 64'(recv_stall), 64'(1));
      chk("t3_wait_valid", 64'(recv_valid), 64'(0));
      tick();
    end
    exp_q.push_back({6'd1, 32'd7});
    exec_proc = 6'd1; dst_proc = 6'd3; send_data = 32'd7; send = 1'b1;
    tick();
    send = 1'b0;
    chk("t3_send_valid", 64'(recv_valid), 64'(0));
    chk("t3_send_stall", 64'(recv_stall), 64'(1));
    tick();
    chk("t3_deliver_valid", 64'(recv_valid), 64'(1));
    chk("t3_deliver_stall", 64'(recv_stall), 64'(0));
    tick();
    chk("t3_after_valid", 64'(recv_valid), 64'(0));
    check_flags("t3");

    // Nine sends into eight slots, then in-order drain.
    for (int i = 0; i < 9; i++) do_send(6'($urandom_range(0, 62)), 6'd1, 32'(i));
    check_flags("t4_full");
    for (int i = 0; i < 8; i++) do_recv_hit(6'd1);
    check_flags("t4_drain");

    // Full queue: send during DELIVER is still dropped.
    do_reset();
    for (int i = 0; i < 8; i++) do_send(6'd7, 6'd2, 32'(i + 16));
    h = mq.pop_front();
    exp_q.push_back({h.src, h.data});
    exec_proc = 6'd2; receive = 1'b1;
    tick();
    receive = 1'b0;
    chk("t5_deliver", 64'(recv_valid), 64'(1));
    exec_proc = 6'd4; dst_proc = 6'd2; send_data = 32'hAA; send = 1'b1;
    m_ovf = 1'b1;
    tick();
    send = 1'b0;
    check_flags("t5");
    for (int i = 0; i < 7; i++) do_recv_hit(6'd2);
    check_flags("t5_drain");

    // All-ones destination.
    do_send(6'd1, 6'h3F, 32'd9);
`ifdef MSGQ_BROADCAST_EN
    do_recv_hit(6'd4);
    check_flags("t6");
    do_send(6'd1, 6'd9, 32'd1);
    exec_proc = 6'd3; receive = 1'b1;
    tick();
    receive = 1'b0;
`else
    exec_proc = 6'd4; receive = 1'b1;
    tick();
    receive = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_stall", 64'(recv_stall), 64'(1));
      chk("t6_valid", 64'(recv_valid), 64'(0));
      tick();
    end
`endif

    // Overfill while a receiver waits, then reset mid-WAIT.
    for (int i = 0; i < 9; i++) do_send(6'd1, 6'd9, 32'(i));
    check_flags("t1_pre");
    chk("t1_pre_stall", 64'(recv_stall), 64'(1));
    #2;
    rst = 1'b1;
    mq.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    tick();
    chk("t1_stall", 64'(recv_stall), 64'(0));
    check_flags("t1");
    rst = 1'b0;
    tick();
    chk("t1_rel_stall", 64'(recv_stall), 64'(0));
    check_flags("t1_rel");

    // Randomized mix of sends and matching receives.
    for (int k = 0; k < 300; k++) begin
      int op;
      logic [PROC_W-1:0] proc;
      logic [PROC_W-1:0] dst;
      op = $urandom_range(0, 9);
      if (op < 5) begin
        case ($urandom_range(0, 3))
          0:       dst = 6'd1;
          1:       dst = 6'd2;
          2:       dst = 6'd5;
          default: dst = 6'h3F;
        endcase
        do_send(6'($urandom_range(0, 63)), dst, 32'($urandom));
      end else if (op < 9 && mq.size() > 0) begin
        proc = mq[0].dst;
`ifdef MSGQ_BROADCAST_EN
        if (mq[0].dst == 6'h3F) proc = 6'($urandom_range(0, 10));
`endif
        do_recv_hit(proc);
      end else begin
        tick();
      end
      if (k % 25 == 0) check_flags("rand");
    end
    check_flags("rand_end");
    tick();
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
